// File: rtl/axil_sram_slave_if.sv
// AXI4-Lite bus bundle between an initiator (ifu/lsu side) and the SRAM responder.
interface axil_sram_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // Read address / read data channels
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    // Write address / write data / write response channels
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output araddr, arvalid, rready,
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready,
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axil_sram_slave.sv
// AXI4-Lite responder backed by a word-addressed on-chip array. Read and write
// channels run independent FSMs with a fixed, programmable response latency.
module axil_sram_slave #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MEM_DEPTH  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                    RD_LATENCY = 2,
    parameter int                    WR_LATENCY = 2
) (
    input logic              clock,
    input logic              reset,
    axil_sram_slave_if.slave bus
);
    localparam int NUM_LANES = DATA_WIDTH / 8;
    localparam int IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int RC_W      = $clog2(RD_LATENCY + 2);
    localparam int WC_W      = $clog2(WR_LATENCY + 2);
    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(4 * MEM_DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

    // Subtraction-based check so BASE_ADDR + size may wrap the address space
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return (a >= BASE_ADDR) && ((a - BASE_ADDR) < MEM_BYTES);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // ---------------- read channel ----------------
    r_state_t              r_state_q, r_state_d;
    logic [RC_W-1:0]       r_cnt_q, r_cnt_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic                  rd_sample;
    logic [ADDR_WIDTH-1:0] rd_addr;

    // Read FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            r_cnt_q   <= '0;
            araddr_q  <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_cnt_q   <= r_cnt_d;
            araddr_q  <= araddr_d;
        end
    end

    // Read FSM next state; rd_sample marks the edge that loads rdata from the array
    always_comb begin
        r_state_d = r_state_q;
        r_cnt_d   = r_cnt_q;
        araddr_d  = araddr_q;
        rd_sample = 1'b0;
        rd_addr   = araddr_q;
        case (r_state_q)
            R_IDLE: begin
                if (bus.arvalid) begin
                    araddr_d = bus.araddr;
                    r_cnt_d  = RC_W'(RD_LATENCY);
                    if (RD_LATENCY == 0) begin
                        r_state_d = R_RESP;
                        rd_sample = 1'b1;
                        rd_addr   = bus.araddr;
                    end else begin
                        r_state_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                r_cnt_d = r_cnt_q - RC_W'(1);
                if (r_cnt_q == RC_W'(1)) begin
                    r_state_d = R_RESP;
                    rd_sample = 1'b1;
                end
            end
            R_RESP: begin
                if (bus.rready) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Registered array read; unlike the control flops it reads the array directly
    // so the array maps onto block RAM with its output register.
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (rd_sample) begin
            if (in_range(rd_addr)) begin
                rdata_q <= mem[word_idx(rd_addr)];
                rresp_q <= RESP_OKAY;
            end else begin
                rdata_q <= '0;
                rresp_q <= RESP_SLVERR;
            end
        end
    end

    // Read channel outputs
    always_comb begin
        bus.arready = !reset && (r_state_q == R_IDLE);
        bus.rvalid  = (r_state_q == R_RESP);
        bus.rdata   = rdata_q;
        bus.rresp   = rresp_q;
    end

    // ---------------- write channel ----------------
    w_state_t              w_state_q, w_state_d;
    logic [WC_W-1:0]       w_cnt_q, w_cnt_d;
    logic                  aw_got_q, aw_got_d, w_got_q, w_got_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [NUM_LANES-1:0]  wstrb_q, wstrb_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  aw_hs, w_hs, wr_commit, wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [NUM_LANES-1:0]  wr_strb;

    // Write FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            w_state_q <= W_IDLE;
            w_cnt_q   <= '0;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            w_cnt_q   <= w_cnt_d;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bresp_q   <= bresp_d;
        end
    end

    // Write FSM next state; AW and W latch independently, commit happens on entry to W_RESP
    always_comb begin
        w_state_d = w_state_q;
        w_cnt_d   = w_cnt_q;
        aw_got_d  = aw_got_q;
        w_got_d   = w_got_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        wr_commit = 1'b0;
        aw_hs     = (w_state_q == W_IDLE) && !aw_got_q && bus.awvalid;
        w_hs      = (w_state_q == W_IDLE) && !w_got_q && bus.wvalid;
        // With zero latency the commit uses the beat arriving on this very edge
        wr_addr   = aw_hs ? bus.awaddr : awaddr_q;
        wr_data   = w_hs ? bus.wdata : wdata_q;
        wr_strb   = w_hs ? bus.wstrb : wstrb_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_got_d = 1'b1;
                    awaddr_d = bus.awaddr;
                end
                if (w_hs) begin
                    w_got_d = 1'b1;
                    wdata_d = bus.wdata;
                    wstrb_d = bus.wstrb;
                end
                if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) begin
                    aw_got_d = 1'b0;
                    w_got_d  = 1'b0;
                    w_cnt_d  = WC_W'(WR_LATENCY);
                    if (WR_LATENCY == 0) begin
                        w_state_d = W_RESP;
                        wr_commit = 1'b1;
                    end else begin
                        w_state_d = W_WAIT;
                    end
                end
            end
            W_WAIT: begin
                w_cnt_d = w_cnt_q - WC_W'(1);
                if (w_cnt_q == WC_W'(1)) begin
                    w_state_d = W_RESP;
                    wr_commit = 1'b1;
                end
            end
            W_RESP: begin
                if (bus.bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
        bresp_d = wr_commit ? (in_range(wr_addr) ? RESP_OKAY : RESP_SLVERR) : bresp_q;
        // A reset on the commit edge drops the write entirely
        wr_en   = wr_commit && !reset && in_range(wr_addr);
    end

    // Byte-lane write into the array; not reset, contents survive reset
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (wr_strb[i]) mem[word_idx(wr_addr)][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // Write channel outputs
    always_comb begin
        bus.awready = !reset && (w_state_q == W_IDLE) && !aw_got_q;
        bus.wready  = !reset && (w_state_q == W_IDLE) && !w_got_q;
        bus.bvalid  = (w_state_q == W_RESP);
        bus.bresp   = bresp_q;
    end
endmodule

// File: tb/tb_axil_sram_slave.sv
// Scoreboard bench: dut0 uses latency 2/2, dut1 latency 0/0. Stimulus pushes
// expected responses; a per-DUT monitor pops and compares on each response.
module tb_axil_sram_slave;
    typedef struct { logic [31:0] data; logic [1:0] resp; int lat; } rd_exp_t;
    typedef struct { logic [1:0] resp; int lat; } wr_exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    rd_exp_t rq[2][$];
    wr_exp_t bq[2][$];

    logic [31:0] araddr[2], awaddr[2], wdata[2], rdata[2];
    logic [3:0]  wstrb[2];
    logic [1:0]  rresp[2], bresp[2];
    logic        arvalid[2], arready[2], rvalid[2], rready[2];
    logic        awvalid[2], awready[2], wvalid[2], wready[2], bvalid[2], bready[2];

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic to_fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        axil_sram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
        assign bus.araddr  = araddr[gi];
        assign bus.arvalid = arvalid[gi];
        assign bus.rready  = rready[gi];
        assign bus.awaddr  = awaddr[gi];
        assign bus.awvalid = awvalid[gi];
        assign bus.wdata   = wdata[gi];
        assign bus.wstrb   = wstrb[gi];
        assign bus.wvalid  = wvalid[gi];
        assign bus.bready  = bready[gi];
        assign arready[gi] = bus.arready;
        assign rdata[gi]   = bus.rdata;
        assign rresp[gi]   = bus.rresp;
        assign rvalid[gi]  = bus.rvalid;
        assign awready[gi] = bus.awready;
        assign wready[gi]  = bus.wready;
        assign bresp[gi]   = bus.bresp;
        assign bvalid[gi]  = bus.bvalid;

        axil_sram_slave #(
            .RD_LATENCY((gi == 0) ? 2 : 0),
            .WR_LATENCY((gi == 0) ? 2 : 0)
        ) u_dut (
            .clock (clk),
            .reset (rst),
            .bus   (bus)
        );

        // Monitor: latency, data/resp and ready-drop checks against the queues
        initial begin
            int ar_c, aw_c, w_c;
            bit ar_seen, aw_seen, w_seen, rv_prev, bv_prev;
            ar_c = 0; aw_c = 0; w_c = 0;
            ar_seen = 0; aw_seen = 0; w_seen = 0; rv_prev = 0; bv_prev = 0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    ar_seen = 0; aw_seen = 0; w_seen = 0; rv_prev = 0; bv_prev = 0;
                end else begin
                    if (ar_seen) chk($sformatf("d%0d_arready_low", gi), arready[gi], 0);
                    if (aw_seen) chk($sformatf("d%0d_awready_low", gi), awready[gi], 0);
                    if (w_seen)  chk($sformatf("d%0d_wready_low", gi), wready[gi], 0);
                    if (rvalid[gi]) begin
                        if (rq[gi].size() == 0) begin
                            if (!rv_prev) chk($sformatf("d%0d_unexpected_rvalid", gi), rvalid[gi], 0);
                        end else begin
                            if (!rv_prev) chk($sformatf("d%0d_rd_latency", gi), cyc, ar_c + rq[gi][0].lat);
                            chk($sformatf("d%0d_rdata", gi), rdata[gi], rq[gi][0].data);
                            chk($sformatf("d%0d_rresp", gi), rresp[gi], rq[gi][0].resp);
                            if (rready[gi]) begin
                                $display("[%0t] dut%0d READ  data=%h resp=%b", $time, gi, rdata[gi], rresp[gi]);
                                void'(rq[gi].pop_front());
                                ar_seen = 0;
                            end
                        end
                    end
                    if (bvalid[gi]) begin
                        if (bq[gi].size() == 0) begin
                            if (!bv_prev) chk($sformatf("d%0d_unexpected_bvalid", gi), bvalid[gi], 0);
                        end else begin
                            if (!bv_prev) chk($sformatf("d%0d_wr_latency", gi), cyc,
                                              ((aw_c > w_c) ? aw_c : w_c) + bq[gi][0].lat);
                            chk($sformatf("d%0d_bresp", gi), bresp[gi], bq[gi][0].resp);
                            if (bready[gi]) begin
                                $display("[%0t] dut%0d WRITE resp=%b", $time, gi, bresp[gi]);
                                void'(bq[gi].pop_front());
                                aw_seen = 0;
                                w_seen  = 0;
                            end
                        end
                    end
                    rv_prev = rvalid[gi];
                    bv_prev = bvalid[gi];
                    if (arvalid[gi] && arready[gi]) begin ar_seen = 1; ar_c = cyc + 1; end
                    if (awvalid[gi] && awready[gi]) begin aw_seen = 1; aw_c = cyc + 1; end
                    if (wvalid[gi] && wready[gi])   begin w_seen = 1;  w_c = cyc + 1;  end
                end
            end
        end
    end

    // All handshake tasks are entered and left just after a rising edge
    task automatic ar_hs(input int k, input logic [31:0] a);
        int n = 0;
        araddr[k] = a; arvalid[k] = 1'b1;
        do begin @(negedge clk); n++; end while (!arready[k] && n < 50);
        if (!arready[k]) to_fail("ar_handshake");
        @(posedge clk); #1;
        arvalid[k] = 1'b0;
    endtask

    task automatic aw_hs(input int k, input logic [31:0] a);
        int n = 0;
        awaddr[k] = a; awvalid[k] = 1'b1;
        do begin @(negedge clk); n++; end while (!awready[k] && n < 50);
        if (!awready[k]) to_fail("aw_handshake");
        @(posedge clk); #1;
        awvalid[k] = 1'b0;
    endtask

    task automatic w_hs(input int k, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        wdata[k] = d; wstrb[k] = s; wvalid[k] = 1'b1;
        do begin @(negedge clk); n++; end while (!wready[k] && n < 50);
        if (!wready[k]) to_fail("w_handshake");
        @(posedge clk); #1;
        wvalid[k] = 1'b0;
    endtask

    task automatic rd(input int k, input logic [31:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r);
        rd_exp_t e;
        e.data = exp_d; e.resp = exp_r; e.lat = lat_of(k);
        rq[k].push_back(e);
        ar_hs(k, a);
    endtask

    task automatic wr(input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [1:0] exp_r, input int aw_dly, input int w_dly);
        wr_exp_t e;
        e.resp = exp_r; e.lat = lat_of(k);
        bq[k].push_back(e);
        fork
            begin
                repeat (aw_dly) begin @(posedge clk); #1; end
                aw_hs(k, a);
            end
            begin
                repeat (w_dly) begin @(posedge clk); #1; end
                w_hs(k, d, s);
            end
        join
    endtask

    task automatic wait_idle(input int k);
        int n = 0;
        while ((rq[k].size() != 0 || bq[k].size() != 0) && n < 100) begin
            @(posedge clk); n++;
        end
        if (rq[k].size() != 0 || bq[k].size() != 0) begin
            to_fail($sformatf("d%0d_response", k));
            rq[k].delete();
            bq[k].delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            arvalid[k] = 0; awvalid[k] = 0; wvalid[k] = 0; rready[k] = 1; bready[k] = 1;
            araddr[k] = '0; awaddr[k] = '0; wdata[k] = '0; wstrb[k] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("d%0d_rst_arready", k), arready[k], 0);
            chk($sformatf("d%0d_rst_awready", k), awready[k], 0);
            chk($sformatf("d%0d_rst_wready", k), wready[k], 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("d%0d_post_arready", k), arready[k], 1);
            chk($sformatf("d%0d_post_awready", k), awready[k], 1);
            chk($sformatf("d%0d_post_wready", k), wready[k], 1);
            chk($sformatf("d%0d_post_rvalid", k), rvalid[k], 0);
            chk($sformatf("d%0d_post_bvalid", k), bvalid[k], 0);
            chk($sformatf("d%0d_post_rdata", k), rdata[k], 0);
            chk($sformatf("d%0d_post_rresp", k), rresp[k], 0);
            chk($sformatf("d%0d_post_bresp", k), bresp[k], 0);
        end
        @(posedge clk); #1;

        // Basic word write then read, latency 2
        wr(0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 0, 0); wait_idle(0);
        rd(0, 32'h8000_0010, 32'hDEAD_BEEF, 2'b00); wait_idle(0);
        // Low address bits ignored
        rd(0, 32'h8000_0013, 32'hDEAD_BEEF, 2'b00); wait_idle(0);

        // Byte strobes: lanes 0 and 2 overwritten
        wr(0, 32'h8000_0020, 32'h1122_3344, 4'hF, 2'b00, 0, 0); wait_idle(0);
        wr(0, 32'h8000_0020, 32'hAABB_CCDD, 4'b0101, 2'b00, 0, 0); wait_idle(0);
        rd(0, 32'h8000_0020, 32'h11BB_33DD, 2'b00); wait_idle(0);
        // Empty strobe commits nothing but still answers OKAY
        wr(0, 32'h8000_0020, 32'hFFFF_FFFF, 4'h0, 2'b00, 0, 0); wait_idle(0);
        rd(0, 32'h8000_0020, 32'h11BB_33DD, 2'b00); wait_idle(0);

        // Channel ordering: W three cycles early, then AW three cycles early
        wr(0, 32'h8000_0030, 32'hCAFE_0001, 4'hF, 2'b00, 3, 0); wait_idle(0);
        wr(0, 32'h8000_0034, 32'hCAFE_0002, 4'hF, 2'b00, 0, 3); wait_idle(0);
        rd(0, 32'h8000_0030, 32'hCAFE_0001, 2'b00); wait_idle(0);
        rd(0, 32'h8000_0034, 32'hCAFE_0002, 2'b00); wait_idle(0);

        // Address boundaries: last word in range, below base, one past the end
        wr(0, 32'h8000_0FFC, 32'h7777_8888, 4'hF, 2'b00, 0, 0); wait_idle(0);
        rd(0, 32'h8000_0FFC, 32'h7777_8888, 2'b00); wait_idle(0);
        wr(0, 32'h8000_0000, 32'h0123_4567, 4'hF, 2'b00, 0, 0); wait_idle(0);
        rd(0, 32'h7FFF_FFFC, 32'h0000_0000, 2'b10); wait_idle(0);
        wr(0, 32'h8000_1000, 32'h5555_5555, 4'hF, 2'b10, 0, 0); wait_idle(0);
        rd(0, 32'h8000_0000, 32'h0123_4567, 2'b00); wait_idle(0);

        // Read sample and write commit on the same edge: old data, then new
        fork
            rd(0, 32'h8000_0010, 32'hDEAD_BEEF, 2'b00);
            wr(0, 32'h8000_0010, 32'h600D_600D, 4'hF, 2'b00, 0, 0);
        join
        wait_idle(0);
        rd(0, 32'h8000_0010, 32'h600D_600D, 2'b00); wait_idle(0);

        // Zero latency with read backpressure and a concurrent write
        wr(1, 32'h8000_0008, 32'h1357_9BDF, 4'hF, 2'b00, 0, 0); wait_idle(1);
        rready[1] = 1'b0;
        fork
            rd(1, 32'h8000_0008, 32'h1357_9BDF, 2'b00);
            wr(1, 32'h8000_000C, 32'h2468_ACE0, 4'hF, 2'b00, 0, 0);
        join
        repeat (5) @(posedge clk);
        #1;
        rready[1] = 1'b1;
        wait_idle(1);
        rd(1, 32'h8000_000C, 32'h2468_ACE0, 2'b00); wait_idle(1);

        // Reset while a write sits in W_WAIT: never committed, no response
        wr(0, 32'h8000_0040, 32'h0BAD_F00D, 4'hF, 2'b00, 0, 0); wait_idle(0);
        awaddr[0] = 32'h8000_0040; wdata[0] = 32'hFFFF_0000; wstrb[0] = 4'hF;
        awvalid[0] = 1'b1; wvalid[0] = 1'b1;
        @(negedge clk);
        chk("d0_rw_awready", awready[0], 1);
        chk("d0_rw_wready", wready[0], 1);
        @(posedge clk); #1;
        awvalid[0] = 1'b0; wvalid[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("d0_rw_rst_awready", awready[0], 0);
        chk("d0_rw_rst_arready", arready[0], 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("d0_rw_post_arready", arready[0], 1);
        chk("d0_rw_post_awready", awready[0], 1);
        chk("d0_rw_post_wready", wready[0], 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("d0_rw_no_bvalid", bvalid[0], 0);
        end
        @(posedge clk); #1;
        rd(0, 32'h8000_0040, 32'h0BAD_F00D, 2'b00); wait_idle(0);

        wait_idle(1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
